sorted_pkt_dedup: RTL and testbench

//  Downstream stage of main_sort. Takes ascending-sorted Avalon-ST packets and drops

---
 rtl/sorted_pkt_dedup.sv | 156 +++++++++++++++
 tb/tb_sorted_pkt_dedup.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sorted_pkt_dedup.sv
// sorted_pkt_dedup
//   Drops adjacent duplicate words from ascending-sorted Avalon-ST packets.
//   Each distinct value is emitted once per packet, with sop/eop placed correctly.
//   One word is held back (lookahead) so eop can be placed on the last unique word.
//   Duplicates are counted, and framing errors raise a one-cycle err_o pulse.
// Ports
//   clk_i, srst_i             clock, synchronous active-high reset
//   snk_*                     Avalon-ST sink (data/sop/eop/valid in, ready out)
//   src_*                     Avalon-ST source (registered data/sop/eop/valid, ready in)
//   drop_cnt_o                saturating count of dropped duplicate words
//   err_o                     pulse: sop while a packet is open, or word without sop while idle
module sorted_pkt_dedup #(
   parameter int DWIDTH = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic [DWIDTH-1:0] snk_data_i,
   input  logic              snk_startofpacket_i,
   input  logic              snk_endofpacket_i,
   input  logic              snk_valid_i,
   output logic              snk_ready_o,
   output logic [DWIDTH-1:0] src_data_o,
   output logic              src_startofpacket_o,
   output logic              src_endofpacket_o,
   output logic              src_valid_o,
   input  logic              src_ready_i,
   output logic [CNT_W-1:0]  drop_cnt_o,
   output logic              err_o
);

   typedef enum logic {IDLE, OPEN} state_t;

   state_t            r_state, w_state_nxt;
   logic [DWIDTH-1:0] r_hold_data, w_hold_data_nxt;
   logic              r_hold_sop, w_hold_sop_nxt;
   logic              r_flush, w_flush_nxt;

   logic              w_load, w_ld_sop, w_ld_eop;
   logic              w_drop, w_err;

   logic [DWIDTH-1:0] r_src_data;
   logic              r_src_vld, r_src_sop, r_src_eop;
   logic [CNT_W-1:0]  r_drop_cnt;
   logic              r_err;

   logic              w_out_free, w_acc, w_same;

   // Output register is free when empty or being drained this cycle.
   assign w_out_free  = !r_src_vld | src_ready_i;
   // While flushing, the held word takes the output slot, so no input is taken.
   assign snk_ready_o = w_out_free & !r_flush;
   assign w_acc       = snk_valid_i & snk_ready_o;
   assign w_same      = (snk_data_i == r_hold_data);

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_hold_data_nxt = r_hold_data;
      w_hold_sop_nxt  = r_hold_sop;
      w_flush_nxt     = r_flush;
      w_load          = 1'b0;
      w_ld_sop        = r_hold_sop;
      w_ld_eop        = 1'b0;
      w_drop          = 1'b0;
      w_err           = 1'b0;
      if (r_flush) begin
         // Close the packet on its held last word as soon as the output frees up.
         if (w_out_free) begin
            w_load      = 1'b1;
            w_ld_eop    = 1'b1;
            w_state_nxt = IDLE;
            w_flush_nxt = 1'b0;
         end
      end else if (w_acc) begin
         if (r_state == IDLE) begin
            if (snk_startofpacket_i) begin
               w_state_nxt     = OPEN;
               w_hold_data_nxt = snk_data_i;
               w_hold_sop_nxt  = 1'b1;
               w_flush_nxt     = snk_endofpacket_i;
            end else begin
               w_err = 1'b1;
            end
         end else if (snk_startofpacket_i) begin
            // New packet while one is still open: force-close the old one.
            w_load          = 1'b1;
            w_ld_eop        = 1'b1;
            w_hold_data_nxt = snk_data_i;
            w_hold_sop_nxt  = 1'b1;
            w_flush_nxt     = snk_endofpacket_i;
            w_err           = 1'b1;
         end else if (w_same) begin
            // Duplicate: the held copy stands in for it, including its eop.
            w_drop = 1'b1;
            if (snk_endofpacket_i) begin
               w_load      = 1'b1;
               w_ld_eop    = 1'b1;
               w_state_nxt = IDLE;
            end
         end else begin
            w_load          = 1'b1;
            w_hold_data_nxt = snk_data_i;
            w_hold_sop_nxt  = 1'b0;
            w_flush_nxt     = snk_endofpacket_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         r_hold_data <= '0;
         r_hold_sop  <= 1'b0;
         r_flush     <= 1'b0;
         r_src_data  <= '0;
         r_src_vld   <= 1'b0;
         r_src_sop   <= 1'b0;
         r_src_eop   <= 1'b0;
         r_drop_cnt  <= '0;
         r_err       <= 1'b0;
      end else begin
         r_hold_data <= w_hold_data_nxt;
         r_hold_sop  <= w_hold_sop_nxt;
         r_flush     <= w_flush_nxt;
         r_err       <= w_err;
         if (w_load) begin
            r_src_data <= r_hold_data;
            r_src_vld  <= 1'b1;
            r_src_sop  <= w_ld_sop;
            r_src_eop  <= w_ld_eop;
         end else if (src_ready_i) begin
            r_src_vld <= 1'b0;
            r_src_sop <= 1'b0;
            r_src_eop <= 1'b0;
         end
         if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign src_data_o          = r_src_data;
   assign src_startofpacket_o = r_src_sop;
   assign src_endofpacket_o   = r_src_eop;
   assign src_valid_o         = r_src_vld;
   assign drop_cnt_o          = r_drop_cnt;
   assign err_o               = r_err;

endmodule

// File: tb/tb_sorted_pkt_dedup.sv
// Bench for sorted_pkt_dedup: directed vector table, hand sequences for
// framing errors and reset, then random packets against a packet-level model.
module tb_sorted_pkt_dedup;

   logic        clk_i = 1'b0;
   logic        srst_i = 1'b1;
   logic [7:0]  snk_data_i = '0;
   logic        snk_startofpacket_i = 1'b0;
   logic        snk_endofpacket_i = 1'b0;
   logic        snk_valid_i = 1'b0;
   logic        snk_ready_o;
   logic [7:0]  src_data_o;
   logic        src_startofpacket_o;
   logic        src_endofpacket_o;
   logic        src_valid_o;
   logic        src_ready_i = 1'b1;
   logic [15:0] drop_cnt_o;
   logic        err_o;

   always #5 clk_i = ~clk_i;

   sorted_pkt_dedup #(.DWIDTH(8), .CNT_W(16)) dut (
      .clk_i(clk_i), .srst_i(srst_i),
      .snk_data_i(snk_data_i), .snk_startofpacket_i(snk_startofpacket_i),
      .snk_endofpacket_i(snk_endofpacket_i), .snk_valid_i(snk_valid_i),
      .snk_ready_o(snk_ready_o),
      .src_data_o(src_data_o), .src_startofpacket_o(src_startofpacket_o),
      .src_endofpacket_o(src_endofpacket_o), .src_valid_o(src_valid_o),
      .src_ready_i(src_ready_i),
      .drop_cnt_o(drop_cnt_o), .err_o(err_o)
   );

   typedef struct packed {logic [7:0] data; logic sop; logic eop;} beat_t;

   typedef struct packed {
      logic [4:0]       n;
      logic [0:15][7:0] w;
      logic [4:0]       nout;
      logic [0:15][7:0] o;
      logic [7:0]       drops;
      logic [3:0]       lat;   // cycles from last input accept to eop beat
   } vec_t;

   beat_t in_q[$], exp_q[$], got_q[$];
   int    got_cyc[$];
   int    checks = 0, errors = 0, cyc = 0, last_acc_cyc = 0;
   int    err_seen = 0, err_exp = 0, drop_exp = 0;
   logic  m_open = 1'b0, m_first = 1'b0;
   logic [7:0] m_last = '0;
   bit    vld_rand = 0, rdy_rand = 0;
   bit    prev_stall = 0;
   beat_t prev_beat;
   vec_t  tbl [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Packet-level reference: a word is known to be final once a different
   // word or the end of its packet is seen.
   function automatic void m_push(input logic [7:0] d, input logic s, input logic e);
      beat_t b;
      b.data = d; b.sop = s; b.eop = e;
      exp_q.push_back(b);
   endfunction

   function automatic void model_accept(input beat_t b);
      if (b.sop) begin
         if (m_open) begin
            err_exp++;
            m_push(m_last, m_first, 1'b1);
         end
         m_open = 1'b1; m_first = 1'b1; m_last = b.data;
      end else if (!m_open) begin
         err_exp++;
      end else if (b.data == m_last) begin
         drop_exp++;
      end else begin
         m_push(m_last, m_first, 1'b0);
         m_first = 1'b0; m_last = b.data;
      end
      if (b.eop && m_open) begin
         m_push(m_last, m_first, 1'b1);
         m_open = 1'b0;
      end
   endfunction

   function automatic void push_beat(input logic [7:0] d, input logic s, input logic e);
      beat_t b;
      b.data = d; b.sop = s; b.eop = e;
      in_q.push_back(b);
   endfunction

   // One cycle: monitor at negedge, then drive just after posedge.
   task automatic step();
      beat_t g, e;
      @(negedge clk_i);
      cyc++;
      if (prev_stall)
         chk("stall_hold", {src_valid_o, src_startofpacket_o, src_endofpacket_o, src_data_o},
             {1'b1, prev_beat.sop, prev_beat.eop, prev_beat.data});
      if (snk_valid_i && snk_ready_o) begin
         model_accept(in_q[0]);
         void'(in_q.pop_front());
         last_acc_cyc = cyc;
      end
      if (src_valid_o && src_ready_i) begin
         g.data = src_data_o; g.sop = src_startofpacket_o; g.eop = src_endofpacket_o;
         got_q.push_back(g);
         got_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL extra_beat: got %0h expected none", g);
         end else begin
            e = exp_q.pop_front();
            chk("beat", g, e);
         end
      end
      if (err_o) err_seen++;
      prev_stall = src_valid_o && !src_ready_i;
      prev_beat.data = src_data_o;
      prev_beat.sop  = src_startofpacket_o;
      prev_beat.eop  = src_endofpacket_o;
      @(posedge clk_i); #1;
      src_ready_i = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (in_q.size() > 0 && (!vld_rand || $urandom_range(0, 3) != 0)) begin
         snk_valid_i = 1'b1;
         snk_data_i = in_q[0].data;
         snk_startofpacket_i = in_q[0].sop;
         snk_endofpacket_i = in_q[0].eop;
      end else begin
         snk_valid_i = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((in_q.size() > 0 || exp_q.size() > 0) && n < 4000) begin
         step();
         n++;
      end
      if (n >= 4000) begin
         checks++; errors++;
         $display("FAIL drain_timeout: got %0d/%0d pending expected 0", in_q.size(), exp_q.size());
      end
      repeat (3) step();
      chk("err_cnt", err_seen, err_exp);
      chk("drop_cnt", drop_cnt_o, drop_exp);
   endtask

   // Entered just after a posedge; leaves just after a posedge with srst low.
   task automatic do_reset();
      srst_i = 1'b1; snk_valid_i = 1'b0; src_ready_i = 1'b0;
      in_q.delete();
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_src", {src_valid_o, src_startofpacket_o, src_endofpacket_o, src_data_o, err_o}, 0);
      chk("rst_cnt", drop_cnt_o, 0);
      @(posedge clk_i); #1;
      srst_i = 1'b0; src_ready_i = 1'b1;
      exp_q.delete(); got_q.delete(); got_cyc.delete();
      m_open = 1'b0; m_first = 1'b0;
      err_seen = 0; err_exp = 0; drop_exp = 0;
      prev_stall = 0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      int len;
      tbl[0] = '{5'd4, {8'd3, 8'd3, 8'd3, 8'd5, 96'd0}, 5'd2, {8'd3, 8'd5, 112'd0}, 8'd2, 4'd2};
      tbl[1] = '{5'd4, {8'd1, 8'd2, 8'd7, 8'd7, 96'd0}, 5'd3, {8'd1, 8'd2, 8'd7, 104'd0}, 8'd1, 4'd1};
      tbl[2] = '{5'd4, {8'd4, 8'd4, 8'd4, 8'd4, 96'd0}, 5'd1, {8'd4, 120'd0}, 8'd3, 4'd1};
      tbl[3] = '{5'd16, {8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7,
                         8'd8, 8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15},
                 5'd16, {8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7,
                         8'd8, 8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15},
                 8'd0, 4'd2};
      tbl[4] = '{5'd1, {8'd9, 120'd0}, 5'd1, {8'd9, 120'd0}, 8'd0, 4'd2};

      @(posedge clk_i); #1;

      // Directed table, full-rate source and sink.
      for (int t = 0; t < 5; t++) begin
         do_reset();
         for (int i = 0; i < int'(tbl[t].n); i++)
            push_beat(tbl[t].w[i], i == 0, i == int'(tbl[t].n) - 1);
         drain();
         chk("tbl_nout", got_q.size(), tbl[t].nout);
         for (int i = 0; i < int'(tbl[t].nout) && i < got_q.size(); i++)
            chk("tbl_beat", got_q[i], {tbl[t].o[i], i == 0, i == int'(tbl[t].nout) - 1});
         chk("tbl_drops", drop_cnt_o, tbl[t].drops);
         if (got_cyc.size() > 0)
            chk("tbl_eop_lat", got_cyc[got_cyc.size()-1] - last_acc_cyc, tbl[t].lat);
      end

      // 0..15 with a randomly stalling sink.
      do_reset();
      rdy_rand = 1;
      for (int i = 0; i < 16; i++) push_beat(8'(i), i == 0, i == 15);
      drain();
      rdy_rand = 0;
      chk("stall_count", got_q.size(), 16);

      // Forced close: sop 9, 9, sop 2, 3(eop).
      do_reset();
      push_beat(8'd9, 1, 0); push_beat(8'd9, 0, 0);
      push_beat(8'd2, 1, 0); push_beat(8'd3, 0, 1);
      drain();
      chk("fc_err", err_seen, 1);
      chk("fc_count", got_q.size(), 3);
      if (got_q.size() == 3) begin
         chk("fc_first", got_q[0], {8'd9, 1'b1, 1'b1});
         chk("fc_open", got_q[1], {8'd2, 1'b1, 1'b0});
      end

      // Reset mid-packet with a beat parked in the output register.
      do_reset();
      push_beat(8'd5, 1, 0); push_beat(8'd5, 0, 0);
      push_beat(8'd6, 0, 0); push_beat(8'd8, 0, 0);
      for (int n = 0; n < 50 && in_q.size() > 0; n++) step();
      do_reset();
      // Hold must be gone: a sop-less 8 with eop is an error, not a close.
      push_beat(8'd8, 0, 1);
      drain();
      chk("nosop_out", got_q.size(), 0);
      chk("nosop_err", err_seen, 1);

      // Random sorted packets with occasional framing faults.
      do_reset();
      vld_rand = 1; rdy_rand = 1;
      for (int p = 0; p < 300; p++) begin
         len = $urandom_range(1, 8);
         d = 8'($urandom_range(0, 255));
         for (int i = 0; i < len; i++) begin
            if (i > 0) d = d + 8'($urandom_range(0, 2));
            push_beat(d, (i == 0) && ($urandom_range(0, 19) != 0),
                         (i == len - 1) && ($urandom_range(0, 19) != 0));
         end
         if (p % 25 == 24) drain();
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
